// File: rtl/ospfb_sample_sched.sv
// Sample scheduler between the input CDC FIFO and the oversampled PFB: passes DEC_FAC
// samples per FFT_LEN-cycle frame, then idles the stream for the remaining gap slots.
module ospfb_sample_sched #(
    parameter int WIDTH        = 16,
    parameter int FFT_LEN      = 64,
    parameter int DEC_FAC      = 48,
    parameter int PRIME_THRESH = 8,
    parameter int CNT_WID      = 5
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       en,
    input  logic [CNT_WID-1:0]         fifo_count,
    input  logic [2*WIDTH-1:0]         s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [2*WIDTH-1:0]         m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [1:0]                 state,
    output logic [$clog2(FFT_LEN)-1:0] slot,
    output logic [15:0]                frame_cnt,
    output logic                       underflow,
    output logic                       underflow_evt
);

    localparam int SW = $clog2(FFT_LEN);
    localparam logic [SW-1:0] DEC_LAST  = SW'(DEC_FAC - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(FFT_LEN - 1);

    if (DEC_FAC < 1 || DEC_FAC >= FFT_LEN) begin : g_param_err
        $error("ospfb_sample_sched: DEC_FAC must satisfy 1 <= DEC_FAC < FFT_LEN");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PRIME = 2'b01,
        RUN   = 2'b10,
        HALT  = 2'b11
    } state_t;

    state_t        cur_state, nxt_state;
    logic [SW-1:0] slot_q, slot_nxt;
    logic [15:0]   frame_q, frame_nxt;
    logic          uf_q, uf_nxt;
    logic          evt_q, evt_nxt;

    logic active;
    logic stall;
    logic uf_cond;
    logic primed;

    // Handshake: a beat moves only when tvalid and tready are both high on a rising
    // edge. The block never buffers, so it is a pure gate between the two sides:
    // upstream sees ready only while the OSPFB is ready, downstream sees valid only
    // while the FIFO is valid, and both are masked outside active slots.
    assign active        = (cur_state == RUN) && (slot_q <= DEC_LAST);
    assign stall         = active && !m_axis_tready;
    assign uf_cond       = active && m_axis_tready && !s_axis_tvalid;
    assign primed        = 32'(fifo_count) >= PRIME_THRESH;

    assign m_axis_tvalid = active && s_axis_tvalid;
    assign s_axis_tready = active && m_axis_tready;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tlast  = active && (slot_q == DEC_LAST);

    assign state         = cur_state;
    assign slot          = slot_q;
    assign frame_cnt     = frame_q;
    assign underflow     = uf_q;
    assign underflow_evt = evt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_state <= IDLE;
            slot_q    <= '0;
            frame_q   <= '0;
            uf_q      <= 1'b0;
            evt_q     <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            slot_q    <= slot_nxt;
            frame_q   <= frame_nxt;
            uf_q      <= uf_nxt;
            evt_q     <= evt_nxt;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        slot_nxt  = slot_q;
        frame_nxt = frame_q;
        uf_nxt    = uf_q;
        evt_nxt   = 1'b0;
        // Dropping en wins over everything, including a coincident underflow.
        if (!en) begin
            if (cur_state != IDLE) begin
                nxt_state = IDLE;
                slot_nxt  = '0;
            end
        end else begin
            unique case (cur_state)
                IDLE: begin
                    nxt_state = PRIME;
                    uf_nxt    = 1'b0;
                end
                PRIME: begin
                    if (primed) begin
                        nxt_state = RUN;
                        slot_nxt  = '0;
                    end
                end
                RUN: begin
                    // Slot is frozen on underflow so HALT reports where the FIFO ran dry.
                    if (uf_cond) begin
                        nxt_state = HALT;
                        uf_nxt    = 1'b1;
                        evt_nxt   = 1'b1;
                    end else if (!stall) begin
                        if (slot_q == SLOT_LAST) begin
                            slot_nxt  = '0;
                            frame_nxt = frame_q + 16'd1;
                        end else begin
                            slot_nxt = slot_q + SW'(1);
                        end
                    end
                end
                HALT: begin
                    nxt_state = HALT;
                end
                default: begin
                    nxt_state = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ospfb_sample_sched.sv
// Self-checking bench for ospfb_sample_sched: directed scenarios plus a randomized run
// compared against a frame-level behavioural model and a data scoreboard.
module tb_ospfb_sample_sched;

    localparam int WIDTH        = 16;
    localparam int FFT_LEN      = 64;
    localparam int DEC_FAC      = 48;
    localparam int PRIME_THRESH = 8;
    localparam int CNT_WID      = 5;
    localparam int SW           = $clog2(FFT_LEN);
    localparam int OW           = 2 + SW + 16 + 5;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 en = 1'b0;
    logic [CNT_WID-1:0]   fifo_count = '0;
    logic [2*WIDTH-1:0]   s_axis_tdata = '0;
    logic                 s_axis_tvalid = 1'b0;
    logic                 s_axis_tready;
    logic [2*WIDTH-1:0]   m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready = 1'b0;
    logic                 m_axis_tlast;
    logic [1:0]           state;
    logic [SW-1:0]        slot;
    logic [15:0]          frame_cnt;
    logic                 underflow;
    logic                 underflow_evt;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: frame position, frame count, mode (0 idle,1 prime,2 run,3 halt)
    int m_state, m_slot, m_frame;
    bit m_uf, m_evt;
    logic [2*WIDTH-1:0] exp_q[$];

    ospfb_sample_sched #(
        .WIDTH(WIDTH), .FFT_LEN(FFT_LEN), .DEC_FAC(DEC_FAC),
        .PRIME_THRESH(PRIME_THRESH), .CNT_WID(CNT_WID)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en), .fifo_count(fifo_count),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .state(state), .slot(slot), .frame_cnt(frame_cnt),
        .underflow(underflow), .underflow_evt(underflow_evt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    task automatic model_reset();
        m_state = 0; m_slot = 0; m_frame = 0; m_uf = 0; m_evt = 0;
        exp_q.delete();
    endtask

    function automatic bit model_gate();
        return (m_state == 2) && (m_slot < DEC_FAC);
    endfunction

    function automatic logic [OW-1:0] exp_vec();
        bit g = model_gate();
        return {2'(m_state), SW'(m_slot), 16'(m_frame), m_uf, m_evt,
                g && s_axis_tvalid, g && m_axis_tready, g && (m_slot == DEC_FAC - 1)};
    endfunction

    function automatic logic [OW-1:0] obs_vec();
        return {state, slot, frame_cnt, underflow, underflow_evt,
                m_axis_tvalid, s_axis_tready, m_axis_tlast};
    endfunction

    // Advance model with the inputs present at the edge, then clock the DUT.
    task automatic tick();
        int ns = m_state;
        int nsl = m_slot;
        int nf = m_frame;
        bit nu = m_uf;
        bit ne = 0;
        if (!en) begin
            if (m_state != 0) begin ns = 0; nsl = 0; end
        end else if (m_state == 0) begin
            ns = 1; nu = 0;
        end else if (m_state == 1) begin
            if (int'(fifo_count) >= PRIME_THRESH) begin ns = 2; nsl = 0; end
        end else if (m_state == 2) begin
            if (m_slot >= DEC_FAC) begin
                nsl = (m_slot + 1) % FFT_LEN;
            end else if (m_axis_tready && !s_axis_tvalid) begin
                ns = 3; nu = 1; ne = 1;
            end else if (m_axis_tready) begin
                nsl = (m_slot + 1) % FFT_LEN;
            end
            if (ns == 2 && nsl == 0 && m_slot == FFT_LEN - 1) nf = (m_frame + 1) % 65536;
        end
        @(posedge clk);
        #1;
        m_state = ns; m_slot = nsl; m_frame = nf; m_uf = nu; m_evt = ne;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit v, input bit r);
        s_axis_tvalid = v;
        m_axis_tready = r;
        s_axis_tdata  = $urandom();
        #2;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0; en = 1'b0;
        model_reset();
        drive(1'b1, 1'b1);
        n_tests++;
        if (obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", obs_vec());
        end
        @(posedge clk); #3;
        rstn = 1'b1;
    endtask

    task automatic test_priming();
        en = 1'b1; fifo_count = '0;
        drive(1'b1, 1'b1);
        tick();
        for (int c = 0; c < PRIME_THRESH; c++) begin
            fifo_count = CNT_WID'(c);
            drive(1'b1, 1'b1);
            n_tests++;
            if (state !== 2'b01 || s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL prime_hold: count=%0d got state=%b rdy=%b vld=%b required 01 0 0",
                         c, state, s_axis_tready, m_axis_tvalid);
            end
            tick();
        end
        fifo_count = CNT_WID'(PRIME_THRESH);
        drive(1'b1, 1'b1);
        tick();
        n_tests++;
        if (state !== 2'b10 || slot !== '0) begin
            n_fail++;
            $display("FAIL prime_start: got state=%b slot=%0d required 10 0", state, slot);
        end
    endtask

    task automatic test_steady_run();
        int xfers = 0;
        int lasts = 0;
        for (int c = 0; c < 3 * FFT_LEN; c++) begin
            drive(1'b1, 1'b1);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL steady_outputs: cycle=%0d got %h required %h", c, obs_vec(), exp_vec());
            end
            if (m_axis_tvalid && m_axis_tready) begin
                xfers++;
                if (m_axis_tlast) begin
                    lasts++;
                    n_tests++;
                    if (xfers % DEC_FAC != 0) begin
                        n_fail++;
                        $display("FAIL steady_tlast_pos: got tlast at transfer %0d required multiple of %0d",
                                 xfers, DEC_FAC);
                    end
                end
            end
            tick();
        end
        n_tests++;
        if (xfers != 3 * 48 || lasts != 3 || frame_cnt !== 16'd3 || slot !== '0) begin
            n_fail++;
            $display("FAIL steady_totals: got xfers=%0d lasts=%0d frame=%0d slot=%0d required 144 3 3 0",
                     xfers, lasts, frame_cnt, slot);
        end
    endtask

    task automatic test_backpressure();
        int cycles = 0;
        int xfers = 0;
        for (int c = 0; c < 200; c++) begin
            drive(1'b1, !(cycles >= 20 && cycles < 25));
            if (cycles >= 20 && cycles < 25) begin
                n_tests++;
                if (slot !== SW'(20) || s_axis_tready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_hold: cycle=%0d got slot=%0d rdy=%b required 20 0",
                             cycles, slot, s_axis_tready);
                end
            end
            if (m_axis_tvalid && m_axis_tready) xfers++;
            tick();
            cycles++;
            if (frame_cnt == 16'd4) break;
        end
        n_tests++;
        if (cycles != 69 || xfers != 48) begin
            n_fail++;
            $display("FAIL bp_frame: got cycles=%0d xfers=%0d required 69 48", cycles, xfers);
        end
    endtask

    task automatic test_underflow();
        for (int c = 0; c < 30; c++) begin
            drive(1'b1, 1'b1);
            tick();
        end
        drive(1'b0, 1'b1);
        n_tests++;
        if (slot !== SW'(30) || m_axis_tvalid !== 1'b0 || underflow_evt !== 1'b0) begin
            n_fail++;
            $display("FAIL uf_pre: got slot=%0d vld=%b evt=%b required 30 0 0",
                     slot, m_axis_tvalid, underflow_evt);
        end
        tick();
        n_tests++;
        if (underflow_evt !== 1'b1 || underflow !== 1'b1 || state !== 2'b11 || slot !== SW'(30)) begin
            n_fail++;
            $display("FAIL uf_event: got evt=%b uf=%b state=%b slot=%0d required 1 1 11 30",
                     underflow_evt, underflow, state, slot);
        end
        drive(1'b1, 1'b1);
        tick();
        n_tests++;
        if (underflow_evt !== 1'b0 || underflow !== 1'b1 || state !== 2'b11 || slot !== SW'(30)
            || s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL uf_halt: got evt=%b uf=%b state=%b slot=%0d rdy=%b required 0 1 11 30 0",
                     underflow_evt, underflow, state, slot, s_axis_tready);
        end
        en = 1'b0;
        drive(1'b1, 1'b1);
        tick();
        n_tests++;
        if (state !== 2'b00 || underflow !== 1'b1 || slot !== '0 || frame_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL uf_idle: got state=%b uf=%b slot=%0d frame=%0d required 00 1 0 4",
                     state, underflow, slot, frame_cnt);
        end
        en = 1'b1;
        drive(1'b1, 1'b1);
        tick();
        n_tests++;
        if (state !== 2'b01 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL uf_reprime: got state=%b uf=%b required 01 0", state, underflow);
        end
        tick();
    endtask

    task automatic test_en_priority();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 1'b1);
            tick();
        end
        en = 1'b0;
        drive(1'b0, 1'b1);
        tick();
        n_tests++;
        if (state !== 2'b00 || underflow_evt !== 1'b0 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL en_priority: got state=%b evt=%b uf=%b required 00 0 0",
                     state, underflow_evt, underflow);
        end
        en = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        int lasts = 0;
        drive(1'b1, 1'b1);
        tick();
        tick();
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 1'b1);
            tick();
        end
        drive(1'b1, 1'b1);
        rstn = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got %h required 0", obs_vec());
        end
        @(posedge clk); #3;
        rstn = 1'b1;
        drive(1'b1, 1'b1);
        tick();
        tick();
        n_tests++;
        if (state !== 2'b10 || slot !== '0) begin
            n_fail++;
            $display("FAIL reset_restart: got state=%b slot=%0d required 10 0", state, slot);
        end
        for (int c = 0; c < DEC_FAC; c++) begin
            drive(1'b1, 1'b1);
            if (m_axis_tlast) lasts++;
            tick();
        end
        n_tests++;
        if (lasts != 1 || frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_tlast: got lasts=%0d frame=%0d required 1 0", lasts, frame_cnt);
        end
    endtask

    task automatic test_random();
        exp_q.delete();
        for (int c = 0; c < 3000; c++) begin
            en         = ($urandom_range(0, 99) < 97);
            fifo_count = CNT_WID'($urandom_range(0, 31));
            drive($urandom_range(0, 99) < 93, $urandom_range(0, 99) < 80);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rand_outputs: cycle=%0d got %h required %h", c, obs_vec(), exp_vec());
            end
            if (model_gate() && s_axis_tvalid && m_axis_tready) exp_q.push_back(s_axis_tdata);
            if (m_axis_tvalid && m_axis_tready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_data: cycle=%0d got unexpected beat %h required none", c, m_axis_tdata);
                end else begin
                    logic [2*WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    if (m_axis_tdata !== e) begin
                        n_fail++;
                        $display("FAIL rand_data: cycle=%0d got %h required %h", c, m_axis_tdata, e);
                    end
                end
            end
            tick();
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drain: got %0d pending beats required 0", exp_q.size());
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        model_reset();
        test_reset();
        test_priming();
        test_steady_run();
        test_backpressure();
        test_underflow();
        test_en_priority();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ospfb_sample_sched.md
OSPFB_SAMPLE_SCHED -- requirements
Module: ospfb_sample_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 16: real/imag component width; samples are 2*WIDTH bits as {im, re}.
REQ-002 SHALL have parameter FFT_LEN, default 64: frame period in cycles, one OSPFB output frame.
REQ-003 SHALL have parameter DEC_FAC, default 48: new samples accepted per frame; 1 <= DEC_FAC < FFT_LEN, otherwise elaboration error.
REQ-004 SHALL have parameter PRIME_THRESH, default 8: minimum FIFO occupancy to start a run.
REQ-005 SHALL have parameter CNT_WID, default 5: width of fifo_count.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port en, input, 1: run request.
REQ-009 SHALL have port fifo_count, input, CNT_WID: read-side occupancy of the upstream CDC FIFO.
REQ-010 SHALL have ports s_axis_tdata (input, 2*WIDTH), s_axis_tvalid (input, 1) and s_axis_tready (output, 1): slave side from the FIFO.
REQ-011 SHALL have ports m_axis_tdata (output, 2*WIDTH), m_axis_tvalid (output, 1), m_axis_tready (input, 1) and m_axis_tlast (output, 1): master side to the OSPFB.
REQ-012 SHALL have port state, output, 2: IDLE=00, PRIME=01, RUN=10, HALT=11.
REQ-013 SHALL have port slot, output, $clog2(FFT_LEN): position within the frame.
REQ-014 SHALL have port frame_cnt, output, 16: completed frames, wrapping.
REQ-015 SHALL have port underflow, output, 1: sticky underflow flag.
REQ-016 SHALL have port underflow_evt, output, 1: one-cycle pulse on underflow.

Function
REQ-017 SHALL define active = (state==RUN) && (slot < DEC_FAC).
REQ-018 SHALL drive m_axis_tvalid = active & s_axis_tvalid, s_axis_tready = active & m_axis_tready and m_axis_tdata = s_axis_tdata, all combinational with zero latency.
REQ-019 SHALL assert m_axis_tlast only when active and slot == DEC_FAC-1.
REQ-020 SHALL never assert s_axis_tready or m_axis_tvalid outside RUN or in slots DEC_FAC..FFT_LEN-1 (the gap slots).
REQ-021 SHALL go IDLE->PRIME when en=1.
REQ-022 SHALL go PRIME->RUN when en=1 and fifo_count >= PRIME_THRESH, loading slot=0 on entry.
REQ-023 SHALL go RUN->HALT on underflow, defined as active && m_axis_tready && !s_axis_tvalid.
REQ-024 SHALL go from any non-IDLE state to IDLE on the next edge when en=0; en=0 takes priority over every other transition.
REQ-025 SHALL leave HALT only via en=0, to IDLE.
REQ-026 SHALL advance slot each RUN cycle except on an active stall (active && !m_axis_tready), where slot and all counters hold.
REQ-027 SHALL wrap slot from FFT_LEN-1 to 0 and increment frame_cnt (mod 2^16) on that wrap.
REQ-028 SHALL not advance slot in the underflow cycle, so HALT reports the failing slot.
REQ-029 SHALL pulse underflow_evt in the underflow cycle (registered, visible the next cycle) and set underflow, which clears only on reset or on an IDLE->PRIME transition.
REQ-030 SHALL hold slot and frame_cnt in HALT, and clear slot to 0 on entering IDLE or RUN; frame_cnt clears only on reset.
REQ-031 SHALL treat simultaneous en=0 and an underflow condition as a transition to IDLE, with no underflow_evt and no underflow set.

Reset
REQ-032 SHALL, while rstn=0, force state=IDLE, slot=0, frame_cnt=0, underflow=0, underflow_evt=0, m_axis_tvalid=0, m_axis_tlast=0 and s_axis_tready=0, asynchronously.
REQ-033 SHALL abandon any frame in progress on a reset asserted mid-RUN, with no partial tlast after release.

Verification
REQ-034 Priming: en=1, fifo_count 0..7 then 8 -> state stays PRIME until fifo_count=8, RUN on the next edge, slot=0.
REQ-035 Steady run: FIFO always valid, m_axis_tready=1 -> exactly 48 transfers then 16 gap cycles per 64-cycle frame, tlast on the 48th transfer, frame_cnt=3 after 192 RUN cycles.
REQ-036 Backpressure: m_axis_tready=0 for 5 cycles at slot 20 -> slot holds at 20, no transfer, frame lengthens to 69 cycles, still 48 transfers.
REQ-037 Underflow: s_axis_tvalid=0 at slot 30 -> underflow_evt one pulse, underflow=1, state=HALT, slot=30; en=0 -> IDLE; en=1 -> PRIME with underflow=0.
REQ-038 Gap slots: s_axis_tvalid=1 during slots 48..63 -> s_axis_tready=0, m_axis_tvalid=0, no underflow.
REQ-039 Reset mid-frame: rstn=0 at slot 10 -> all outputs at reset values immediately; after release with en=1 the block re-primes and restarts at slot 0.
